// File: rtl/mem_load_pkg.sv
// mem_load_pkg: shared types and lane-extraction helpers for mem_load_unit.
//   load_size_e  - request size encoding (byte / half / word / reserved)
//   load_rsp_t   - response payload {data, err}
//   load_err     - misalignment / reserved-size check for a request
//   extend_lane  - select the addressed lane of a 32-bit word and extend it
package mem_load_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } load_size_e;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } load_rsp_t;

  function automatic logic load_err(input logic [1:0] off, input load_size_e size);
    logic err;
    case (size)
      LS_BYTE: err = 1'b0;
      LS_HALF: err = off[0];
      LS_WORD: err = (off != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Little-endian lane select; word loads ignore sext. Erroring requests return zero data.
  function automatic load_rsp_t extend_lane(input logic [31:0] word, input logic [1:0] off,
                                            input load_size_e size, input logic sext);
    load_rsp_t   rsp;
    logic [7:0]  lane8;
    logic [15:0] lane16;
    case (off)
      2'd0:    lane8 = word[7:0];
      2'd1:    lane8 = word[15:8];
      2'd2:    lane8 = word[23:16];
      default: lane8 = word[31:24];
    endcase
    lane16   = off[1] ? word[31:16] : word[15:0];
    rsp.err  = load_err(off, size);
    rsp.data = '0;
    if (!rsp.err) begin
      case (size)
        LS_BYTE: rsp.data = {{24{sext & lane8[7]}}, lane8};
        LS_HALF: rsp.data = {{16{sext & lane16[15]}}, lane16};
        LS_WORD: rsp.data = word;
        default: rsp.data = '0;
      endcase
    end
    return rsp;
  endfunction

endpackage

// File: rtl/mem_load_rsp_fifo.sv
// mem_load_rsp_fifo: circular response buffer with occupancy count.
//   clk, rst         - clock, asynchronous active-low reset
//   push, pushData   - write an entry (ignored when full)
//   pop              - drop the head entry (ignored when empty)
//   popData          - head entry (meaningful only when count != 0)
//   count            - number of stored entries
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module mem_load_rsp_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             popData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PtrW-1:0]  wrPtrQ, rdPtrQ;
  logic [CntW-1:0]  countQ;
  logic             doPush, doPop;

  always_comb begin
    doPop  = pop && (countQ != '0);
    doPush = push && (countQ != CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + 1'b1;
      if (doPop)  rdPtrQ <= rdPtrQ + 1'b1;
      case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  // Payload storage needs no reset: count gates whether it is observed.
  always_ff @(posedge clk) begin
    if (doPush) storage[wrPtrQ] <= pushData;
  end

  assign popData = storage[rdPtrQ];
  assign count   = countQ;

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: load path from the MIPS core into DataMemory's synchronous read port.
//   clk, rst                           - clock, asynchronous active-low reset
//   req_valid/req_ready                - load request handshake
//   req_addr, req_size, req_signed     - byte address, size (byte/half/word/rsvd), sign-extend
//   mem_rd_addr, mem_rd_data           - DataMemory word read port (1-cycle latency)
//   rsp_valid/rsp_ready                - buffered response handshake
//   rsp_data, rsp_err                  - extended load data, misaligned/reserved flag
// Optional macro LOAD_FWD_EN adds wr_en/wr_addr/wr_data so a store to the word being read
// in the issue cycle is forwarded to the load instead of the stale rd_data.
module mem_load_unit
  import mem_load_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic [ADDR_W-3:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
`ifdef LOAD_FWD_EN
  input  logic              wr_en,
  input  logic [ADDR_W-3:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned RspW = $bits(load_rsp_t);

  logic              aliveQ;
  logic [ADDR_W-3:0] rdAddrQ;
  logic              inflightQ;
  logic [1:0]        s1OffQ;
  load_size_e        s1SizeQ;
  logic              s1SignedQ;
  logic              s1ErrQ;

  logic              accept;
  logic              issueErr;
  logic [CntW:0]     used;
  logic [CntW-1:0]   fifoCount;
  logic [31:0]       loadWord;
  load_rsp_t         pushRsp;
  load_rsp_t         headRsp;
  logic [RspW-1:0]   headBits;
  logic              fifoPop;

  // Credits cover both buffered and in-flight responses, so a push never finds the FIFO full.
  // aliveQ keeps req_ready low throughout reset and for the edge that releases it.
  always_comb begin
    used      = {1'b0, fifoCount} + (CntW + 1)'(inflightQ);
    req_ready = aliveQ && (used < (CntW + 1)'(RSP_DEPTH));
    accept    = req_valid && req_ready;
    // Combinational on accept so DataMemory returns the word one cycle later.
    mem_rd_addr = accept ? req_addr[ADDR_W-1:2] : rdAddrQ;
    issueErr    = load_err(req_addr[1:0], load_size_e'(req_size));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aliveQ    <= 1'b0;
      rdAddrQ   <= '0;
      inflightQ <= 1'b0;
      s1OffQ    <= '0;
      s1SizeQ   <= LS_BYTE;
      s1SignedQ <= 1'b0;
      s1ErrQ    <= 1'b0;
    end else begin
      aliveQ    <= 1'b1;
      rdAddrQ   <= mem_rd_addr;
      inflightQ <= accept;
      if (accept) begin
        s1OffQ    <= req_addr[1:0];
        s1SizeQ   <= load_size_e'(req_size);
        s1SignedQ <= req_signed;
        s1ErrQ    <= issueErr;
      end
    end
  end

`ifdef LOAD_FWD_EN
  logic              fwdHitQ;
  logic [DATA_W-1:0] fwdDataQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwdHitQ  <= 1'b0;
      fwdDataQ <= '0;
    end else begin
      fwdHitQ  <= accept && wr_en && (wr_addr == mem_rd_addr);
      fwdDataQ <= wr_data;
    end
  end

  assign loadWord = fwdHitQ ? fwdDataQ : mem_rd_data;
`else
  assign loadWord = mem_rd_data;
`endif

  always_comb begin
    if (s1ErrQ) begin
      pushRsp = load_rsp_t'{data: 32'h0, err: 1'b1};
    end else begin
      pushRsp = extend_lane(loadWord, s1OffQ, s1SizeQ, s1SignedQ);
    end
  end

  mem_load_rsp_fifo #(
    .WIDTH (RspW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflightQ),
    .pushData (pushRsp),
    .pop      (fifoPop),
    .popData  (headBits),
    .count    (fifoCount)
  );

  // Outputs are forced to zero when empty so stale storage never leaks out.
  always_comb begin
    headRsp   = load_rsp_t'(headBits);
    rsp_valid = (fifoCount != '0);
    fifoPop   = rsp_valid && rsp_ready;
    rsp_data  = rsp_valid ? headRsp.data : '0;
    rsp_err   = rsp_valid && headRsp.err;
  end

endmodule

// File: tb/tb_mem_load_unit.sv
module tb_mem_load_unit;

  localparam int unsigned RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [10:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [8:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
`ifdef LOAD_FWD_EN
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
`endif

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  logic [31:0] dmem [512];
  logic [32:0] gotQ [$];
  int          gotCyc [$];
  logic [32:0] expQ [$];

  mem_load_unit #(
    .ADDR_W    (11),
    .DATA_W    (32),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
`ifdef LOAD_FWD_EN
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // DataMemory model: synchronous read, data one cycle after the address.
  always @(posedge clk) mem_rd_data <= dmem[mem_rd_addr];

  // Record every accepted response; inputs are stable between negedge and the next posedge.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      gotQ.push_back({rsp_err, rsp_data});
      gotCyc.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: {err, data} from the load rules using plain arithmetic.
  function automatic logic [32:0] model_load(input logic [10:0] a, input logic [1:0] sz,
                                             input logic sg, input logic [31:0] w);
    int unsigned off;
    logic [31:0] v;
    off = {30'd0, a[1:0]};
    if (sz == 2'd3 || (sz == 2'd1 && (off % 2) == 1) || (sz == 2'd2 && off != 0))
      return {1'b1, 32'h0};
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return {1'b0, v};
  endfunction

  task automatic issue(input logic [10:0] a, input logic [1:0] sz, input logic sg,
                       output int accCyc, output logic [8:0] rdSeen);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_addr = a; req_size = sz; req_signed = sg;
    #1;
    while (!req_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      ncmp++; nfail++;
      $display("FAIL issue_timeout req_ready=%0b required 1", req_ready);
    end
    accCyc = cyc;
    rdSeen = mem_rd_addr;
    expQ.push_back(model_load(a, sz, sg, dmem[a[10:2]]));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 200 && gotQ.size() < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    ncmp++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_data !== 32'h0 || mem_rd_addr !== 9'h0) begin
      nfail++;
      $display("FAIL reset_outputs ready=%0b valid=%0b err=%0b data=%08h rdaddr=%0h required all 0",
               req_ready, rsp_valid, rsp_err, rsp_data, mem_rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    ncmp++;
    if (req_ready !== 1'b0) begin
      nfail++;
      $display("FAIL reset_release_ready got %0b required 0", req_ready);
    end
    @(posedge clk); #1;
    ncmp++;
    if (req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL ready_after_reset got %0b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    logic [10:0] tAddr [10] = '{11'h14, 11'h14, 11'h16, 11'h15, 11'h14,
                                11'h15, 11'h16, 11'h14, 11'h14, 11'h17};
    logic [1:0]  tSize [10] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
    logic        tSgn  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [32:0] tExp  [10] = '{{1'b0, 32'hFFFF_FF80}, {1'b0, 32'h0000_0080},
                                {1'b0, 32'hFFFF_8000}, {1'b0, 32'h0000_007F},
                                {1'b0, 32'h8000_7F80}, {1'b1, 32'h0},
                                {1'b1, 32'h0},         {1'b0, 32'h8000_7F80},
                                {1'b1, 32'h0},         {1'b0, 32'h0000_0080}};
    int          base, acc0, acc;
    logic [8:0]  rdSeen;
    logic [32:0] obs;
    base = gotQ.size();
    expQ.delete();
    rsp_ready = 1'b1;
    dmem[5] = 32'h8000_7F80;
    for (int i = 0; i < 10; i++) begin
      issue(tAddr[i], tSize[i], tSgn[i], acc, rdSeen);
      if (i == 0) begin
        acc0 = acc;
        ncmp++;
        if (rdSeen !== 9'd5) begin
          nfail++;
          $display("FAIL issue_rd_addr got %0h required 5", rdSeen);
        end
      end
    end
    drain(base + 10);
    ncmp++;
    if (gotQ.size() != base + 10) begin
      nfail++;
      $display("FAIL directed_count got %0d required 10", gotQ.size() - base);
    end
    for (int i = 0; i < 10; i++) begin
      obs = (gotQ.size() > base + i) ? gotQ[base + i] : 33'bx;
      ncmp++;
      if (obs !== tExp[i]) begin
        nfail++;
        $display("FAIL directed[%0d] got err=%0b data=%08h required err=%0b data=%08h",
                 i, obs[32], obs[31:0], tExp[i][32], tExp[i][31:0]);
      end
    end
    if (gotCyc.size() > base) begin
      ncmp++;
      if (gotCyc[base] != acc0 + 2) begin
        nfail++;
        $display("FAIL first_latency got %0d required %0d", gotCyc[base] - acc0, 2);
      end
    end
  endtask

  task automatic test_stall();
    int          base, accepted;
    logic [10:0] a;
    logic [32:0] snap, obs;
    base = gotQ.size();
    expQ.delete();
    accepted = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a = {9'($urandom_range(0, 511)), 2'b00};
      req_valid = 1'b1; req_addr = a; req_size = 2'd2; req_signed = 1'b0;
      if (req_ready) begin
        expQ.push_back(model_load(a, 2'd2, 1'b0, dmem[a[10:2]]));
        accepted++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    ncmp++;
    if (accepted != RSP_DEPTH || req_ready !== 1'b0) begin
      nfail++;
      $display("FAIL stall_credit accepted=%0d ready=%0b required %0d and 0",
               accepted, req_ready, RSP_DEPTH);
    end
    snap = {rsp_err, rsp_data};
    repeat (3) begin @(posedge clk); #1; end
    ncmp++;
    if (rsp_valid !== 1'b1 || {rsp_err, rsp_data} !== snap) begin
      nfail++;
      $display("FAIL stall_hold valid=%0b data=%09h required 1 and %09h",
               rsp_valid, {rsp_err, rsp_data}, snap);
    end
    rsp_ready = 1'b1;
    drain(base + accepted);
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (gotQ.size() > base + i) ? gotQ[base + i] : 33'bx;
      ncmp++;
      if (obs !== expQ[i]) begin
        nfail++;
        $display("FAIL stall_order[%0d] got %09h required %09h", i, obs, expQ[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          base, acc0, acc;
    logic [8:0]  rdSeen;
    logic [10:0] a;
    logic [32:0] obs;
    base = gotQ.size();
    expQ.delete();
    rsp_ready = 1'b1;
    a = '0;
    for (int i = 0; i < 16; i++) begin
      a = {9'($urandom_range(0, 511)), 2'b00};
      issue(a, 2'd2, 1'($urandom), acc, rdSeen);
      if (i == 0) acc0 = acc;
    end
    drain(base + 16);
    ncmp++;
    if (mem_rd_addr !== a[10:2]) begin
      nfail++;
      $display("FAIL rd_addr_hold got %0h required %0h", mem_rd_addr, a[10:2]);
    end
    for (int i = 0; i < 16; i++) begin
      obs = (gotQ.size() > base + i) ? gotQ[base + i] : 33'bx;
      ncmp++;
      if (obs !== expQ[i] || gotCyc.size() <= base + i || gotCyc[base + i] != acc0 + 2 + i) begin
        nfail++;
        $display("FAIL b2b[%0d] got %09h at cycle %0d required %09h at cycle %0d", i, obs,
                 (gotCyc.size() > base + i) ? gotCyc[base + i] : -1, expQ[i], acc0 + 2 + i);
      end
    end
  endtask

  task automatic test_random();
    int          base;
    logic [32:0] obs;
    base = gotQ.size();
    expQ.delete();
    for (int i = 0; i < 512; i++) dmem[i] = $urandom;
    for (int c = 0; c < 600; c++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = 11'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      if (req_valid && req_ready)
        expQ.push_back(model_load(req_addr, req_size, req_signed, dmem[req_addr[10:2]]));
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain(base + expQ.size());
    ncmp++;
    if (gotQ.size() != base + expQ.size()) begin
      nfail++;
      $display("FAIL random_count got %0d required %0d", gotQ.size() - base, expQ.size());
    end
    for (int i = 0; i < expQ.size(); i++) begin
      obs = (gotQ.size() > base + i) ? gotQ[base + i] : 33'bx;
      ncmp++;
      if (obs !== expQ[i]) begin
        nfail++;
        $display("FAIL random[%0d] got %09h required %09h", i, obs, expQ[i]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int         base, acc;
    logic [8:0] rdSeen;
    rsp_ready = 1'b0;
    issue(11'h20, 2'd2, 1'b0, acc, rdSeen);
    issue(11'h24, 2'd2, 1'b0, acc, rdSeen);
    ncmp++;
    if (rsp_valid !== 1'b1) begin
      nfail++;
      $display("FAIL midop_pending got valid=%0b required 1", rsp_valid);
    end
    rst = 1'b0;
    #1;
    ncmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      nfail++;
      $display("FAIL midop_reset valid=%0b ready=%0b required 0 0", rsp_valid, req_ready);
    end
    base = gotQ.size();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    rsp_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    ncmp++;
    if (gotQ.size() != base || rsp_valid !== 1'b0) begin
      nfail++;
      $display("FAIL midop_stale responses=%0d valid=%0b required 0 0",
               gotQ.size() - base, rsp_valid);
    end
  endtask

`ifdef LOAD_FWD_EN
  task automatic test_forward();
    int base;
    base = gotQ.size();
    dmem[5] = 32'h8000_7F80;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 11'h14; req_size = 2'd2; req_signed = 1'b0;
    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 32'h1234_5678;
    #1;
    for (int k = 0; k < 200 && !req_ready; k++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wr_en = 1'b0;
    dmem[5] = 32'h1234_5678;
    drain(base + 1);
    ncmp++;
    if (gotQ.size() <= base || gotQ[base] !== {1'b0, 32'h1234_5678}) begin
      nfail++;
      $display("FAIL forward got %09h required 012345678",
               (gotQ.size() > base) ? gotQ[base] : 33'bx);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 512; i++) dmem[i] = '0;
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0;
    rsp_ready = 1'b0;
`ifdef LOAD_FWD_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
`ifdef LOAD_FWD_EN
    test_forward();
`endif
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
